// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg: items shared by the fetch controller and its
// next-PC datapath.
//   fetch_state_e  - controller states
//   DEF_RESET_ADDR - default first fetch address after reset
//   DEF_PC_STEP    - default sequential increment in bytes
//   align_word     - clears bits [1:0] of a redirect target
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;
  localparam int unsigned DEF_PC_STEP    = 4;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_controller_next_pc_select.sv
// next_pc_select: combinational next-PC choice for the fetch controller.
//   PCAddress           - current fetch address
//   Jump/JumpTarget     - highest-priority redirect
//   BranchTaken/BranchTarget - second-priority redirect
//   PendValid/PendTarget - redirect captured while a request was outstanding
//   RedirValid/RedirTarget - live redirect (Jump over Branch), word aligned
//   NextPC              - address to fetch after the current one completes
module next_pc_select
  import fetch_controller_pkg::*;
#(
  parameter int unsigned PC_STEP = DEF_PC_STEP
) (
  input  logic [31:0] PCAddress,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        PendValid,
  input  logic [31:0] PendTarget,
  output logic        RedirValid,
  output logic [31:0] RedirTarget,
  output logic [31:0] NextPC
);

  always_comb begin
    RedirValid  = Jump | BranchTaken;
    RedirTarget = Jump ? align_word(JumpTarget) : align_word(BranchTarget);
    // Pending target was already aligned when captured.
    // The sequential add wraps naturally at 32 bits.
    if (RedirValid)     NextPC = RedirTarget;
    else if (PendValid) NextPC = PendTarget;
    else                NextPC = PCAddress + 32'(PC_STEP);
  end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch sequencer.
//   Clk, Reset (async, active-high)
//   Stall, Halt                  - pipeline hold / permanent stop requests
//   Jump/JumpTarget, BranchTaken/BranchTarget - redirect requests
//   MemAck                       - memory accepted the current request
//   PCAddress, FetchReq          - registered request to instruction memory
//   InstrValid, FetchedPC        - registered completion pulse and its address
//   Halted                       - high while stopped
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DEF_RESET_ADDR,
  parameter int unsigned PC_STEP    = DEF_PC_STEP
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Halt,
  input  logic        MemAck,
  output logic [31:0] PCAddress,
  output logic        FetchReq,
  output logic        InstrValid,
  output logic [31:0] FetchedPC,
  output logic        Halted
);

  fetch_state_e state, state_nxt;
  logic         pend_vld, pend_vld_nxt;
  logic [31:0]  pend_addr, pend_addr_nxt;
  logic [31:0]  pc_nxt, fpc_nxt;
  logic         iv_nxt;
  logic         redir_vld;
  logic [31:0]  redir_addr, seq_pc;

  next_pc_select #(.PC_STEP(PC_STEP)) u_npc (
    .PCAddress   (PCAddress),
    .Jump        (Jump),
    .JumpTarget  (JumpTarget),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .PendValid   (pend_vld),
    .PendTarget  (pend_addr),
    .RedirValid  (redir_vld),
    .RedirTarget (redir_addr),
    .NextPC      (seq_pc)
  );

  always_comb begin
    state_nxt     = state;
    pc_nxt        = PCAddress;
    fpc_nxt       = FetchedPC;
    iv_nxt        = 1'b0;
    pend_vld_nxt  = pend_vld;
    pend_addr_nxt = pend_addr;
    case (state)
      IDLE: state_nxt = Halt ? HALTED : (Stall ? HOLD : REQ);
      REQ: begin
        if (FetchReq && MemAck) begin
          fpc_nxt      = PCAddress;
          iv_nxt       = 1'b1;
          pc_nxt       = seq_pc;
          pend_vld_nxt = 1'b0;
          state_nxt    = Halt ? HALTED : (Stall ? HOLD : REQ);
        end else if (redir_vld) begin
          // Address must stay put while the request is outstanding;
          // remember the redirect (latest wins) for the completing ack.
          pend_vld_nxt  = 1'b1;
          pend_addr_nxt = redir_addr;
        end
      end
      HOLD: begin
        if (redir_vld) pc_nxt = redir_addr;
        if (Halt)        state_nxt = HALTED;
        else if (!Stall) state_nxt = REQ;
      end
      HALTED: ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      PCAddress  <= RESET_ADDR;
      FetchReq   <= 1'b0;
      InstrValid <= 1'b0;
      FetchedPC  <= 32'h0;
      Halted     <= 1'b0;
      pend_vld   <= 1'b0;
      pend_addr  <= 32'h0;
    end else begin
      state      <= state_nxt;
      PCAddress  <= pc_nxt;
      FetchReq   <= (state_nxt == REQ);
      InstrValid <= iv_nxt;
      FetchedPC  <= fpc_nxt;
      Halted     <= (state_nxt == HALTED);
      pend_vld   <= pend_vld_nxt;
      pend_addr  <= pend_addr_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        Clk = 1'b0, Reset = 1'b1;
  logic        Stall = 1'b0, Jump = 1'b0, BranchTaken = 1'b0, Halt = 1'b0, MemAck = 1'b0;
  logic [31:0] JumpTarget = 32'h0, BranchTarget = 32'h0;
  logic [31:0] PCAddress, FetchedPC;
  logic        FetchReq, InstrValid, Halted;

  int n_cmp = 0, n_bad = 0;

  always #5 Clk = ~Clk;

  fetch_controller dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Jump(Jump), .JumpTarget(JumpTarget),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Halt(Halt), .MemAck(MemAck),
    .PCAddress(PCAddress), .FetchReq(FetchReq), .InstrValid(InstrValid),
    .FetchedPC(FetchedPC), .Halted(Halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic rq,
                         input logic iv, input logic [31:0] fpc, input logic hl);
    chk({tag, ".pc"},     PCAddress,          pc);
    chk({tag, ".req"},    {31'b0, FetchReq},  {31'b0, rq});
    chk({tag, ".iv"},     {31'b0, InstrValid},{31'b0, iv});
    chk({tag, ".fpc"},    FetchedPC,          fpc);
    chk({tag, ".halted"}, {31'b0, Halted},    {31'b0, hl});
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs;
    Stall = 1'b0; Jump = 1'b0; BranchTaken = 1'b0; Halt = 1'b0; MemAck = 1'b0;
    JumpTarget = 32'h0; BranchTarget = 32'h0;
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 just out of reset, 1 fetching, 2 waiting on stall, 3 stopped.
  int          m_phase;
  logic [31:0] m_pc, m_fpc;
  logic        m_iv;
  logic [31:0] m_pend[$];

  function automatic void m_reset();
    m_phase = 0; m_pc = 32'h0; m_fpc = 32'h0; m_iv = 1'b0;
    m_pend.delete();
  endfunction

  function automatic int after_ack_phase();
    if (Halt)  return 3;
    if (Stall) return 2;
    return 1;
  endfunction

  function automatic void m_edge();
    logic [31:0] tgt;
    logic        redir;
    redir = Jump || BranchTaken;
    tgt   = Jump ? (JumpTarget & ~32'd3) : (BranchTarget & ~32'd3);
    m_iv  = 1'b0;
    if (m_phase == 0) begin
      m_phase = after_ack_phase();
    end else if (m_phase == 1) begin
      if (MemAck) begin
        m_fpc = m_pc;
        m_iv  = 1'b1;
        if (redir)                 m_pc = tgt;
        else if (m_pend.size() > 0) m_pc = m_pend[0];
        else                       m_pc = m_pc + 32'd4;
        m_pend.delete();
        m_phase = after_ack_phase();
      end else if (redir) begin
        m_pend.delete();
        m_pend.push_back(tgt);
      end
    end else if (m_phase == 2) begin
      if (redir) m_pc = tgt;
      if (Halt)        m_phase = 3;
      else if (!Stall) m_phase = 1;
    end
  endfunction

  task automatic cmp_model(input string tag);
    chk_all(tag, m_pc, (m_phase == 1), m_iv, m_fpc, (m_phase == 3));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic s, j; logic [31:0] jt; logic b; logic [31:0] bt; logic h, a;
    logic [31:0] pc; logic rq, iv; logic [31:0] fpc; logic hl;
  } vec_t;

  function automatic vec_t mkv(input logic s, input logic j, input logic [31:0] jt,
                               input logic b, input logic [31:0] bt, input logic h,
                               input logic a, input logic [31:0] pc, input logic rq,
                               input logic iv, input logic [31:0] fpc, input logic hl);
    vec_t v;
    v.s = s; v.j = j; v.jt = jt; v.b = b; v.bt = bt; v.h = h; v.a = a;
    v.pc = pc; v.rq = rq; v.iv = iv; v.fpc = fpc; v.hl = hl;
    return v;
  endfunction

  task automatic do_reset;
    clear_inputs();
    Reset = 1'b1;
    #1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    m_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];

    // Reset is high from time 0: outputs must already hold reset values.
    #2;
    chk_all("reset0", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    //             s     j     jt            b     bt            h     a     pc            rq    iv    fpc           hl
    vecs[0]  = mkv(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0);
    vecs[1]  = mkv(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        1'b1, 1'b1, 32'h0,        1'b0);
    vecs[2]  = mkv(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        1'b1, 1'b1, 32'h4,        1'b0);
    vecs[3]  = mkv(1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       1'b0, 1'b0, 32'h8,        1'b1, 1'b0, 32'h4,        1'b0);
    vecs[4]  = mkv(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h8,        1'b1, 1'b0, 32'h4,        1'b0);
    vecs[5]  = mkv(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h8,        1'b1, 1'b0, 32'h4,        1'b0);
    vecs[6]  = mkv(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h40,       1'b1, 1'b1, 32'h8,        1'b0);
    vecs[7]  = mkv(1'b0, 1'b1, 32'h100,      1'b1, 32'h200,      1'b0, 1'b1, 32'h100,      1'b1, 1'b1, 32'h40,       1'b0);
    vecs[8]  = mkv(1'b0, 1'b1, 32'h103,      1'b0, 32'h0,        1'b0, 1'b1, 32'h100,      1'b1, 1'b1, 32'h100,      1'b0);
    vecs[9]  = mkv(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h100,      1'b1, 1'b0, 32'h100,      1'b0);
    vecs[10] = mkv(1'b0, 1'b0, 32'h0,        1'b1, 32'h500,      1'b0, 1'b0, 32'h100,      1'b1, 1'b0, 32'h100,      1'b0);
    vecs[11] = mkv(1'b0, 1'b1, 32'h602,      1'b0, 32'h0,        1'b0, 1'b0, 32'h100,      1'b1, 1'b0, 32'h100,      1'b0);
    vecs[12] = mkv(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h600,      1'b1, 1'b1, 32'h100,      1'b0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      Stall = vecs[i].s; Jump = vecs[i].j; JumpTarget = vecs[i].jt;
      BranchTaken = vecs[i].b; BranchTarget = vecs[i].bt; Halt = vecs[i].h; MemAck = vecs[i].a;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].rq, vecs[i].iv, vecs[i].fpc, vecs[i].hl);
    end

    // Stall at the ack for PC=16, then resume at 20; reset mid-request at 24.
    do_reset();
    MemAck = 1'b1;
    repeat (5) tick();
    chk_all("stall.pre", 32'h10, 1'b1, 1'b1, 32'hC, 1'b0);
    Stall = 1'b1;
    tick();
    chk_all("stall.ack", 32'h14, 1'b0, 1'b1, 32'h10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("stall.hold%0d", i), 32'h14, 1'b0, 1'b0, 32'h10, 1'b0);
    end
    Stall = 1'b0; MemAck = 1'b0;
    tick();
    chk_all("stall.resume", 32'h14, 1'b1, 1'b0, 32'h10, 1'b0);
    MemAck = 1'b1;
    tick();
    chk_all("stall.fetch20", 32'h18, 1'b1, 1'b1, 32'h14, 1'b0);
    MemAck = 1'b0;
    tick();
    chk_all("midreq.pre", 32'h18, 1'b1, 1'b0, 32'h14, 1'b0);
    Reset = 1'b1;
    #1;
    chk_all("midreq.async", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    MemAck = 1'b1;
    tick();
    tick();
    chk_all("midreq.held", 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    Reset = 1'b0;

    // Address wrap at the top of the space.
    do_reset();
    MemAck = 1'b1;
    tick();
    Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
    tick();
    chk_all("wrap.jump", 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0, 1'b0);
    Jump = 1'b0;
    tick();
    chk_all("wrap.inc", 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);

    // Halt waits for the outstanding ack, then everything freezes.
    MemAck = 1'b0; Halt = 1'b1;
    tick();
    chk_all("halt.wait0", 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0);
    tick();
    chk_all("halt.wait1", 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0);
    MemAck = 1'b1;
    tick();
    chk_all("halt.ack", 32'h4, 1'b0, 1'b1, 32'h0, 1'b1);
    Halt = 1'b0; Jump = 1'b1; JumpTarget = 32'h300;
    tick();
    tick();
    chk_all("halt.frozen", 32'h4, 1'b0, 1'b0, 32'h0, 1'b1);

    // Randomized run against the reference model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 149) == 0) begin
        Reset = 1'b1;
        #1;
        m_reset();
        cmp_model("rnd.rst");
        tick();
        cmp_model("rnd.rsthold");
        Reset = 1'b0;
      end else begin
        Stall        = ($urandom_range(0, 3) == 0);
        Jump         = ($urandom_range(0, 7) == 0);
        JumpTarget   = $urandom;
        BranchTaken  = ($urandom_range(0, 5) == 0);
        BranchTarget = $urandom;
        Halt         = ($urandom_range(0, 299) == 0);
        MemAck       = ($urandom_range(0, 2) != 0);
        m_edge();
        tick();
        cmp_model($sformatf("rnd%0d", cyc));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
